// File: rtl/pe_pkg.sv
// Shared types and constants for the priority-encoder code event path.
package pe_pkg;

  localparam int unsigned CODE_W = 4;

  typedef logic [CODE_W-1:0] pe_code_t;

  localparam pe_code_t CODE_NONE = 4'b0000;
  localparam pe_code_t CODE_MAX  = 4'b1000;

  // A new event is any change onto a non-zero code; releases to zero are ignored.
  function automatic logic is_new_event(input pe_code_t cur, input pe_code_t prev);
    return (cur != prev) && (cur != CODE_NONE);
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Synchronous show-ahead FIFO with explicit level tracking; accepts a write
// when full only if a read happens in the same cycle.
module pe_sync_fifo
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = CODE_W,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (level_q == CNT_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Power-of-two depth lets the pointers wrap naturally.
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/pe_code_event_fifo.sv
// Turns each change to a new non-zero priority-encoder code into one queued event.
// Optional macro PE_DROP_COUNT_EN adds the saturating drop_cnt output.
module pe_code_event_fifo
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  level,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef PE_DROP_COUNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  pe_code_t code_q, code_prev_q;
  pe_code_t head;
  logic     push, pop, drop;
  logic     fifo_full, fifo_empty;
  logic     ovf_q, ovf_d;

  assign push      = is_new_event(code_q, code_prev_q);
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign drop      = push && fifo_full && !pop;
  assign evt_code  = fifo_empty ? CODE_NONE : head;
  assign ovf       = ovf_q;

  pe_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (code_q),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= CODE_NONE;
      code_prev_q <= CODE_NONE;
      ovf_q       <= 1'b0;
    end else begin
      code_q      <= code_in;
      code_prev_q <= code_q;
      ovf_q       <= ovf_d;
    end
  end

`ifdef PE_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pe_code_event_fifo.sv
// Scenario and randomized checks for pe_code_event_fifo against a queue-based model.
module tb_pe_code_event_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       code_in = 4'd0;
  logic             evt_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             evt_valid;
  logic [3:0]       evt_code;
  logic [CNT_W-1:0] level;
  logic             ovf;
`ifdef PE_DROP_COUNT_EN
  logic [7:0]       drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pe_code_event_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef PE_DROP_COUNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Reference model: a queue of pending events plus the two sampled codes.
  int mq[$];
  int m_cq = 0, m_cp = 0, m_drop = 0;
  bit m_ovf = 0, m_pop, m_push, m_full_drop;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_cq = 0; m_cp = 0; m_ovf = 0; m_drop = 0;
      end else begin
        m_pop       = (mq.size() > 0) && evt_ready;
        m_push      = (m_cq != m_cp) && (m_cq != 0);
        m_full_drop = m_push && (mq.size() == DEPTH) && !m_pop;
        if (m_pop) void'(mq.pop_front());
        if (m_push && !m_full_drop) mq.push_back(m_cq);
        if (m_full_drop) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end else if (ovf_clr) m_ovf = 1'b0;
        m_cp = m_cq;
        m_cq = int'(code_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
    n_cmp++; if (evt_code !== 4'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", evt_code); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
`ifdef PE_DROP_COUNT_EN
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single_event();
    int pops = 0;
    code_in = 4'd3; evt_ready = 1'b1;
    tick();
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %0b want 0", evt_valid); end
    tick();
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got %0b want 1", evt_valid); end
    n_cmp++; if (evt_code !== 4'd3) begin n_bad++; $display("FAIL single_code: got %0d want 3", evt_code); end
    if (evt_valid) pops++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (evt_valid) pops++;
    end
    n_cmp++; if (pops != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", pops); end
    evt_ready = 1'b0;
    code_in = 4'd0;
    tick(); tick();
  endtask

  task automatic test_release_not_queued();
    int seq[4] = '{5, 0, 5, 8};
    int exp[3] = '{5, 5, 8};
    for (int i = 0; i < 4; i++) begin
      code_in = 4'(seq[i]);
      repeat (3) tick();
    end
    tick();
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL release_level: got %0d want 3", level); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (evt_code !== 4'(exp[k])) begin n_bad++; $display("FAIL release_pop%0d: got %0d want %0d", k, evt_code, exp[k]); end
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    end
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL release_empty: got %0b want 0", evt_valid); end
  endtask

  task automatic test_full_push_pop();
    int exp[4] = '{2, 3, 4, 6};
    for (int c = 1; c <= 4; c++) begin
      code_in = 4'(c);
      repeat (2) tick();
    end
    tick(); tick();
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fullpp_fill: got %0d want 4", level); end
    code_in = 4'd6;
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fullpp_level: got %0d want 4", level); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fullpp_ovf: got %0b want 0", ovf); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (evt_code !== 4'(exp[k])) begin n_bad++; $display("FAIL fullpp_order%0d: got %0d want %0d", k, evt_code, exp[k]); end
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    for (int c = 1; c <= 5; c++) begin
      code_in = 4'(c);
      repeat (2) tick();
    end
    tick(); tick();
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d want 4", level); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b want 1", ovf); end
    n_cmp++; if (evt_code !== 4'd1) begin n_bad++; $display("FAIL ovf_head: got %0d want 1", evt_code); end
`ifdef PE_DROP_COUNT_EN
    n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
`endif
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovfclr_clear: got %0b want 0", ovf); end
    code_in = 4'd9;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovfclr_setwins: got %0b want 1", ovf); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL ovfclr_level: got %0d want 4", level); end
`ifdef PE_DROP_COUNT_EN
    n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL ovfclr_drop_cnt: got %0d want 2", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b1; repeat (4) tick(); evt_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      code_in = 4'(c);
      repeat (2) tick();
    end
    tick();
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL rstmid_fill: got %0d want 3", level); end
    #3;
    rst_n = 1'b0;
    code_in = 4'd7;
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %0b want 0", evt_valid); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovf: got %0b want 0", ovf); end
    n_cmp++; if (evt_code !== 4'd0) begin n_bad++; $display("FAIL rstmid_code: got %0d want 0", evt_code); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL rstmid_one_event: got %0d want 1", level); end
    n_cmp++; if (evt_code !== 4'd7) begin n_bad++; $display("FAIL rstmid_event_code: got %0d want 7", evt_code); end
  endtask

  task automatic test_random();
    int exp_code;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) code_in = 4'($urandom_range(0, 15));
      // Alternate between drain-heavy and fill-heavy phases to reach full and overflow.
      evt_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      exp_code = (mq.size() > 0) ? mq[0] : 0;
      n_cmp++; if (evt_valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rand_valid @%0d: got %0b want %0b", i, evt_valid, mq.size() > 0); end
      n_cmp++; if (evt_code !== 4'(exp_code)) begin n_bad++; $display("FAIL rand_code @%0d: got %0d want %0d", i, evt_code, exp_code); end
      n_cmp++; if (level !== CNT_W'(mq.size())) begin n_bad++; $display("FAIL rand_level @%0d: got %0d want %0d", i, level, mq.size()); end
      n_cmp++; if (ovf !== m_ovf) begin n_bad++; $display("FAIL rand_ovf @%0d: got %0b want %0b", i, ovf, m_ovf); end
`ifdef PE_DROP_COUNT_EN
      n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_bad++; $display("FAIL rand_drop_cnt @%0d: got %0d want %0d", i, drop_cnt, m_drop); end
`endif
    end
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_event();
    test_release_not_queued();
    test_full_push_pop();
    test_overflow();
    test_ovf_clr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
